capture_readout: RTL and testbench
==================================

Name: capture_readout

Overview:
Reader for the 256 x 32-bit capture RAM filled by the filter test harness. On a start pulse it reads every RAM word in order from address 0, splits each word into 4 bytes, MSB first, and streams them on a valid/ready byte interface to the UART transmitter. This gets filter output off-chip for comparison against the golden model. It shares posClk with the harness and only drives the RAM read port; the harness keeps ownership of writes.

Parameters:
ADDR_W, 8, RAM address width.
DATA_W, 32, RAM word width; must be a multiple of 8.
DEPTH, 256, number of words read per frame; must be ≤ 2^ADDR_W.
RD_LAT, 1, posClk edges from the RAM sampling the address to ramQ being valid; must be ≥ 1.

Ports:
posClk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
ramAddr  out  ADDR_W  registered RAM read address.
ramRdEn  out  1  RAM read strobe; one cycle per word.
ramQ  in  DATA_W  RAM read data.
txData  out  8  byte to transmitter.
txValid  out  1  txData is valid.
txReady  in  1  transmitter accepts the byte this cycle.
busy  out  1  high from the cycle after start is accepted until the frame completes.
done  out  1  single-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ramAddr=0, ramRdEn=0, txData=0, txValid=0, busy=0, done=0; shift register, byte counter and word counter all cleared.
- IDLE: if start=1, then ramAddr<=0, busy<=1, go to RD_REQ. Otherwise hold.
- RD_REQ (1 cycle): ramRdEn=1 and ramAddr stable. Go to RD_WAIT with the wait counter set to RD_LAT.
- RD_WAIT: decrement the wait counter each cycle. At the RD_LAT-th edge after leaving RD_REQ, latch ramQ into the shift register, set the byte counter to 0, assert txValid, and go to SEND.
- SEND:
  - txData is shift[DATA_W-1:DATA_W-8].
  - While txValid=1 and txReady=0, hold txData and txValid unchanged.
  - On a handshake (txValid & txReady), shift left by 8 and increment the byte counter.
  - After the (DATA_W/8)th handshake, drop txValid. If ramAddr==DEPTH-1, go to FIN (or CSUM, see Optional Feature). Otherwise ramAddr<=ramAddr+1 and go to RD_REQ.
- FIN: done=1 and busy=0 for exactly this cycle, then go to IDLE.
- Timing with RD_LAT=1 and txReady held at 1:
  - txValid rises after the 2nd edge following the edge that samples start.
  - Each word takes 6 cycles (RD_REQ 1, RD_WAIT 1, SEND 4).
  - done rises the edge after the last handshake.
- ramAddr does not wrap within a frame; each frame restarts at 0.
- start is ignored in every state except IDLE, including the FIN cycle.
- Reset asserted mid-frame aborts immediately with no done pulse. The frame in progress is lost; the next start begins at address 0.
- txValid never drops without a handshake, except on reset.

Optional Feature:
Macro READOUT_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator clears when start is accepted and adds each handshaken data byte, modulo 256.
  - After the last data byte the block enters CSUM and sends one extra byte equal to (~sum+1) mod 256, so all frame bytes sum to 0 mod 256.
  - The CSUM byte uses the same handshake rules as data bytes; FIN follows its handshake.
  - Frame length is DEPTH*DATA_W/8+1 bytes.
- Undefined: no accumulator and no CSUM state; frame length is DEPTH*DATA_W/8 bytes.

Decomposition:
- Shared package filter_test_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, SEND, CSUM, FIN);
  - BYTES_PER_WORD = DATA_W/8;
  - capture RAM depth and width constants shared with the harness.
- One sub-module, word_serializer, is the natural split. It takes a load strobe and a DATA_W word, and emits MSB-first bytes under valid/ready, plus a last-byte flag. The FSM and address counter stay in capture_readout.

Test Plan:
1. RAM model word k = k*32'h01010101, RD_LAT=1, txReady=1, pulse start → 1024 bytes, bytes 4k..4k+3 all equal k; 6 cycles per word; done high for exactly 1 cycle, the edge after the last handshake; busy low on the same edge.
2. Word 0 = 32'hDEADBEEF → first 4 bytes are DE, AD, BE, EF in that order.
3. txReady randomly low about 40% of cycles → same byte sequence as test 1; txData and txValid stable on every cycle with txValid=1 and txReady=0; ramRdEn asserted exactly 256 times.
4. start pulsed while busy → no effect on sequence or timing; start after done → new frame from address 0, identical bytes.
5. rst low during byte 2 of word 5 → all outputs 0 in the same cycle, no done pulse; start after release → frame from address 0.
6. READOUT_CHECKSUM_EN, word 0 = 32'h00000005 and all others 0 → 1025 bytes, last byte 8'hFB; all words = 32'h00000001 → last byte 8'h00.

Source files
------------

// File: rtl/filter_test_pkg.sv
// -----------------------------------------------------------------------------
// filter_test_pkg
// Definitions shared by the filter test harness and the capture RAM readout.
//   - state_t        : readout FSM states
//   - CAP_ADDR_W     : capture RAM address width
//   - CAP_DATA_W     : capture RAM word width (multiple of 8)
//   - CAP_DEPTH      : number of capture RAM words
//   - BYTES_PER_WORD : bytes carried by one capture RAM word
//   - csum_byte()    : byte that brings a running mod-256 sum back to zero
// -----------------------------------------------------------------------------
package filter_test_pkg;

    localparam int CAP_ADDR_W     = 8;
    localparam int CAP_DATA_W     = 32;
    localparam int CAP_DEPTH      = 256;
    localparam int BYTES_PER_WORD = CAP_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        CSUM    = 3'd4,
        FIN     = 3'd5
    } state_t;

    // Two's complement of the running sum: adding it to the sum gives 0 mod 256.
    function automatic logic [7:0] csum_byte(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/capture_readout_if.sv
// -----------------------------------------------------------------------------
// capture_readout_if
// Bus bundle between the capture readout and its surroundings: the capture RAM
// read port and the valid/ready byte stream towards the UART transmitter.
//   ramAddr / ramRdEn : read address and read strobe (readout -> RAM)
//   ramQ              : read data (RAM -> readout)
//   txData / txValid  : byte and its valid flag (readout -> transmitter)
//   txReady           : transmitter accepts the byte (transmitter -> readout)
// Modports: master = readout side, slave = RAM/transmitter side.
// -----------------------------------------------------------------------------
interface capture_readout_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] ramAddr;
    logic              ramRdEn;
    logic [DATA_W-1:0] ramQ;
    logic [7:0]        txData;
    logic              txValid;
    logic              txReady;

    modport master (
        output ramAddr,
        output ramRdEn,
        input  ramQ,
        output txData,
        output txValid,
        input  txReady
    );

    modport slave (
        input  ramAddr,
        input  ramRdEn,
        output ramQ,
        input  txData,
        input  txValid,
        output txReady
    );

endinterface

// File: rtl/capture_readout_word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Splits a DATA_W word into bytes, MSB first, and presents them under a
// valid/ready handshake. A load can also carry a single byte (word MSB byte
// only), which is then the last byte.
// Ports:
//   posClk   : clock, rising edge
//   rst      : asynchronous reset, active low
//   i_load   : load i_word this cycle (takes priority over shifting)
//   i_word   : word to serialize
//   i_single : the loaded word carries only its MSB byte
//   i_ready  : consumer accepts o_data this cycle
//   o_data   : current byte
//   o_valid  : o_data is valid
//   o_last   : current byte is the final one of the loaded word
// -----------------------------------------------------------------------------
module word_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              posClk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_single,
    input  logic              i_ready,
    output logic [7:0]        o_data,
    output logic              o_valid,
    output logic              o_last
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_single;
    logic              w_last;
    logic              w_hs;

    assign w_last  = r_single || (r_cnt == CNT_W'(BYTES - 1));
    assign w_hs    = r_valid && i_ready;
    assign o_data  = r_shift[DATA_W-1 -: 8];
    assign o_valid = r_valid;
    assign o_last  = w_last;

    // Byte stage: load, then shift one byte out per handshake
    always_ff @(posedge posClk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_single <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_word;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_single <= i_single;
        end else if (w_hs) begin
            r_shift <= r_shift << 8;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capture_readout.sv
// -----------------------------------------------------------------------------
// capture_readout
// Reads the whole capture RAM from address 0 on a start pulse and streams every
// word as bytes, MSB first, to the UART transmitter. Only the RAM read port is
// driven here; the harness owns the write port.
// Ports:
//   posClk : clock, rising edge
//   rst    : asynchronous reset, active low
//   start  : begin a frame (only looked at in IDLE)
//   busy   : frame in progress
//   done   : one-cycle pulse when the frame is complete
//   bus    : capture_readout_if.master (RAM read port + byte stream)
// Build option:
//   READOUT_CHECKSUM_EN : append one byte so that all frame bytes sum to 0
//                         mod 256.
// -----------------------------------------------------------------------------
module capture_readout
    import filter_test_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DATA_W = CAP_DATA_W,
    parameter int DEPTH  = CAP_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic                    posClk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    capture_readout_if.master       bus
);

    localparam int                WAIT_W    = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rden;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_busy;
    logic               r_done;

    logic               w_load_word;
    logic               w_load;
    logic [DATA_W-1:0]  w_word;
    logic               w_single;
    logic [7:0]         w_txData;
    logic               w_txValid;
    logic               w_last;
    logic               w_hs;

    assign w_hs        = w_txValid && bus.txReady;
    // ramQ is valid on the edge that ends the wait count
    assign w_load_word = (r_state == RD_WAIT) && (r_wait == WAIT_W'(1));

`ifdef READOUT_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_load_csum;

    // The checksum byte is loaded on the same edge the last data byte is
    // accepted, so the sum must include that byte here.
    assign w_load_csum = (r_state == SEND) && w_hs && w_last && (r_addr == LAST_ADDR);
    assign w_load      = w_load_word || w_load_csum;
    assign w_single    = w_load_csum;
    assign w_word      = w_load_csum ? {csum_byte(r_sum + w_txData), {(DATA_W-8){1'b0}}}
                                     : bus.ramQ;
`else
    assign w_load   = w_load_word;
    assign w_single = 1'b0;
    assign w_word   = bus.ramQ;
`endif

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_word_serializer (
        .posClk   (posClk),
        .rst      (rst),
        .i_load   (w_load),
        .i_word   (w_word),
        .i_single (w_single),
        .i_ready  (bus.txReady),
        .o_data   (w_txData),
        .o_valid  (w_txValid),
        .o_last   (w_last)
    );

    assign bus.ramAddr = r_addr;
    assign bus.ramRdEn = r_rden;
    assign bus.txData  = w_txData;
    assign bus.txValid = w_txValid;
    assign busy        = r_busy;
    assign done        = r_done;

    // Control stage: frame sequencing, RAM address and read strobe
    always_ff @(posedge posClk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rden  <= 1'b0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_rden  <= 1'b1;
                        r_state <= RD_REQ;
`ifdef READOUT_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end

                RD_REQ: begin
                    r_rden  <= 1'b0;
                    r_wait  <= WAIT_W'(RD_LAT);
                    r_state <= RD_WAIT;
                end

                RD_WAIT: begin
                    r_wait <= r_wait - 1'b1;
                    if (r_wait == WAIT_W'(1)) begin
                        r_state <= SEND;
                    end
                end

                SEND: begin
                    if (w_hs) begin
`ifdef READOUT_CHECKSUM_EN
                        r_sum <= r_sum + w_txData;
`endif
                        if (w_last) begin
                            if (r_addr == LAST_ADDR) begin
`ifdef READOUT_CHECKSUM_EN
                                r_state <= CSUM;
`else
                                r_state <= FIN;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
`endif
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_rden  <= 1'b1;
                                r_state <= RD_REQ;
                            end
                        end
                    end
                end

                CSUM: begin
                    if (w_hs) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// -----------------------------------------------------------------------------
// tb_capture_readout
// Directed bench for capture_readout with a synchronous RAM model (one edge
// read latency) and a byte-stream model built from the RAM contents.
// Define READOUT_CHECKSUM_EN for the checksum build.
// -----------------------------------------------------------------------------
module tb_capture_readout;
    import filter_test_pkg::*;

    localparam int DEPTH = 256;
    localparam int BYTES = 4;
`ifdef READOUT_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic posClk = 1'b0;
    logic rst    = 1'b0;
    logic start  = 1'b0;
    logic busy;
    logic done;

    capture_readout_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    capture_readout #(
        .ADDR_W (8),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .RD_LAT (1)
    ) dut (
        .posClk (posClk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 posClk = ~posClk;

    logic [31:0] mem [0:DEPTH-1];

    always @(posedge posClk) begin
        if (bus.ramRdEn) bus.ramQ <= mem[bus.ramAddr];
    end

    int cyc = 0;
    always @(posedge posClk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int  exp_idx, rden_cnt, done_cnt, first_vld_cyc, done_cyc, last_hs_cyc, c0;
    bit  frame_done;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected frame: every RAM word MSB byte first, then optionally the byte
    // that makes the whole frame sum to zero.
    task automatic build_model();
        int sum;
        exp_q.delete();
        sum = 0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int b = 0; b < BYTES; b++) begin
                logic [7:0] v;
                v = 8'((mem[k] >> (8 * (BYTES - 1 - b))) & 32'hFF);
                exp_q.push_back(v);
                sum = sum + int'(v);
            end
        end
        if (CSUM_BYTES == 1) exp_q.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge posClk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.ramRdEn) rden_cnt++;
            if (bus.txValid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid_hold", int'(bus.txValid), 1);
                check("stall_data_hold", int'(bus.txData), int'(prev_data));
            end
            if (bus.txValid && bus.txReady) begin
                if (exp_idx < exp_q.size())
                    check($sformatf("byte%0d", exp_idx), int'(bus.txData), int'(exp_q[exp_idx]));
                else
                    check("byte_past_frame_end", exp_idx, exp_q.size() - 1);
                cap_q.push_back(bus.txData);
                exp_idx++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                frame_done = 1'b1;
                check("done_after_last_hs", cyc, last_hs_cyc + 1);
                check("done_byte_count", exp_idx, exp_q.size());
                check("busy_low_with_done", int'(busy), 0);
            end
            prev_stall = bus.txValid && !bus.txReady;
            prev_data  = bus.txData;
        end
    end

    task automatic start_frame();
        build_model();
        cap_q.delete();
        exp_idx       = 0;
        rden_cnt      = 0;
        done_cnt      = 0;
        first_vld_cyc = -1;
        last_hs_cyc   = -10;
        frame_done    = 1'b0;
        @(posedge posClk); #1;
        start = 1'b1;
        c0    = cyc + 1;
        @(posedge posClk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int low_pct, input bit timing, input bit poke, input string tag);
        start_frame();
        for (int n = 0; n < 30000 && !frame_done; n++) begin
            bus.txReady = ($urandom_range(0, 99) >= low_pct);
            start       = poke && busy && (n % 37 == 5);
            @(posedge posClk); #1;
        end
        start       = 1'b0;
        bus.txReady = 1'b1;
        check({tag, "_done_seen"}, int'(frame_done), 1);
        repeat (3) @(posedge posClk);
        #1;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_bytes"}, exp_idx, exp_q.size());
        check({tag, "_rden_count"}, rden_cnt, DEPTH);
        if (timing) begin
            check({tag, "_first_valid_cyc"}, first_vld_cyc, c0 + 2);
            check({tag, "_done_cyc"}, done_cyc, c0 + DEPTH * (BYTES + 2) + CSUM_BYTES);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.txReady = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = k * 32'h01010101;

        // Reset state
        #12;
        check("rst_ramAddr", int'(bus.ramAddr), 0);
        check("rst_ramRdEn", int'(bus.ramRdEn), 0);
        check("rst_txData", int'(bus.txData), 0);
        check("rst_txValid", int'(bus.txValid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(posedge posClk); #1;
        rst = 1'b1;

        // Test 1: ramp pattern, always ready, timing
        run_frame(0, 1'b1, 1'b0, "t1");
        check("t1_frame_len", cap_q.size(), 1024 + CSUM_BYTES);
        check("t1_byte29", int'(cap_q[29]), 8'h07);
        check("t1_byte1023", int'(cap_q[1023]), 8'hFF);

        // Test 2: MSB-first order
        mem[0] = 32'hDEADBEEF;
        run_frame(0, 1'b1, 1'b0, "t2");
        check("t2_b0", int'(cap_q[0]), 8'hDE);
        check("t2_b1", int'(cap_q[1]), 8'hAD);
        check("t2_b2", int'(cap_q[2]), 8'hBE);
        check("t2_b3", int'(cap_q[3]), 8'hEF);
        mem[0] = 32'h0;

        // Test 3: back-pressure about 40% of cycles
        run_frame(40, 1'b0, 1'b0, "t3");

        // Test 4: start while busy, then back-to-back frame
        run_frame(0, 1'b1, 1'b1, "t4a");
        run_frame(0, 1'b1, 1'b0, "t4b");

        // Test 5: reset during the second byte of word 5
        start_frame();
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge posClk); #1;
            if (exp_idx == 21 && bus.txValid) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_rst_point_reached", int'(found), 1);
        check("t5_pre_rst_addr", int'(bus.ramAddr), 5);
        rst = 1'b0;
        #1;
        check("t5_ramAddr", int'(bus.ramAddr), 0);
        check("t5_ramRdEn", int'(bus.ramRdEn), 0);
        check("t5_txData", int'(bus.txData), 0);
        check("t5_txValid", int'(bus.txValid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        repeat (4) @(posedge posClk);
        #1;
        check("t5_no_done", done_cnt, 0);
        rst = 1'b1;
        run_frame(0, 1'b1, 1'b0, "t5_after");
        check("t5_after_b8", int'(cap_q[8]), 8'h02);

`ifdef READOUT_CHECKSUM_EN
        // Test 6: checksum byte
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
        mem[0] = 32'h00000005;
        run_frame(0, 1'b1, 1'b0, "t6a");
        check("t6a_len", cap_q.size(), 1025);
        check("t6a_csum", int'(cap_q[1024]), 8'hFB);
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h00000001;
        run_frame(30, 1'b0, 1'b0, "t6b");
        check("t6b_len", cap_q.size(), 1025);
        check("t6b_csum", int'(cap_q[1024]), 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
